fetch_prefetch_buffer: RTL and testbench
========================================

Name: fetch_prefetch_buffer

Overview:
Parametrised instruction prefetch unit for the RV32IC fetch stage.
- Keeps up to NUM_REQS instruction-bus requests in flight.
- Buffers returned words in a DEPTH-entry shift FIFO.
- Realigns 16/32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Presents one instruction at a time to decode over a valid/ready handshake.
- Handles redirects with in-flight discard, and bus errors, which the previous fetch stage ignored.

Parameters:
- PC_RESET, 32'h0, address fetched first after reset.
- NUM_REQS, 2, maximum outstanding bus requests (1..4).
- DEPTH, NUM_REQS+1, FIFO entries (>= NUM_REQS+1).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- fetch_en_i  in  1  allow new bus requests
- redirect_i  in  1  branch/trap redirect, single-cycle pulse
- redirect_addr_i  in  32  new PC; bit0 ignored
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  request accepted
- instr_addr_o  out  32  word-aligned request address
- instr_rvalid_i  in  1  response valid, in request order
- instr_rdata_i  in  32  response data
- instr_err_i  in  1  response error, qualified by rvalid
- out_valid_o  out  1  instruction available
- out_ready_i  in  1  decode accepts
- out_instr_o  out  32  instruction; compressed instructions zero-extended in [31:16]
- out_pc_o  out  32  PC of out_instr_o
- out_compressed_o  out  1  instr[1:0] != 2'b11
- out_err_o  out  1  fetch error for this PC
- busy_o  out  1  outstanding != 0 or FIFO occupied

Behaviour:
Reset (rstn low, async):
- FIFO empty, outstanding = 0, discard = 0.
- fetch_addr = PC_RESET & ~3; out_pc = PC_RESET.
- instr_req_o = 0, out_valid_o = 0, out_err_o = 0, busy_o = 0.

Request side:
- instr_req_o = fetch_en_i & ~redirect_i & (outstanding + occupied < DEPTH) & (outstanding < NUM_REQS).
- Hold instr_req_o and instr_addr_o stable until gnt.
- On req & gnt: fetch_addr += 4, outstanding += 1.
- On rvalid: outstanding -= 1.
- Simultaneous grant and rvalid leave outstanding unchanged.

Response side:
- rvalid with discard == 0: push {rdata, err} into the lowest free entry.
- If an entry is popped the same cycle, the push lands one slot lower.
- rvalid with discard != 0: drop the response, discard -= 1.
- The space check above guarantees no overflow. Overflow is an assertion failure.

Aligner (entry0 = word at out_pc[31:2]):
- Aligned (pc[1] = 0): valid when entry0 occupied. Compressed if entry0[1:0] != 11.
- Unaligned compressed (pc[1] = 1, entry0[17:16] != 11): valid on entry0 alone.
- Unaligned 32-bit: instr = {entry1[15:0], entry0[31:16]}. Valid when entry1 occupied, or the current rvalid carries that half (bypass, same cycle).
- Error: entry0.err sets out_valid_o with out_err_o = 1 and out_instr_o = 0. The upper half counts as errored if the contributing entry1 has err.

Consume (out_valid & out_ready):
- out_pc += 2 if compressed, else 4.
- Pop entry0 when the instruction ends at or beyond the word's upper half: aligned 32-bit, unaligned compressed, unaligned 32-bit.
- An unaligned 32-bit consume pops only entry0; entry1 becomes entry0 with pc[1] = 1.
- After an error instruction, out_valid_o stays low until the next redirect.

Redirect (highest priority, same cycle as any other event):
- Flush FIFO; discard := outstanding minus rvalid accepted this cycle.
- fetch_addr := redirect_addr & ~3; out_pc := redirect_addr & ~1.
- instr_req_o forced 0 this cycle; requests resume next cycle.
- out_valid_o in the redirect cycle is ignored, whatever out_ready_i does.
- An unaligned target fetches the containing word; its lower half is never presented.

Ordering: responses are never reordered; out_pc increases monotonically between redirects.

Decomposition:
- Shared package fetch_pkg:
  - typedef fifo_entry_t {logic [31:0] data; logic err;}
  - localparam OPC_UNCOMPRESSED = 2'b11
  - function is_compressed(logic [1:0]).
- One sub-module, fetch_aligner: combinational. Takes entry0, entry1, bypass word, occupancy and pc[1]. Outputs instr, valid, compressed, err, pop.
- Counters and FIFO stay in the top module.

Test Plan:
- Reset with PC_RESET = 32'h100, fetch_en = 1, gnt/rvalid every cycle, memory words 32-bit NOPs → out_pc 0x100, 0x104, 0x108 on consecutive cycles; never more than 2 outstanding.
- Word 0x0001_4501 (two compressed) followed by 0x0000_0013 → out_pc 0x100 (instr 0x4501), 0x102 (instr 0x0001), 0x104; entry0 popped only after 0x102.
- Redirect to 0x202 with 2 outstanding; word at 0x200 = 0x0513_0001, word at 0x204 = 0x0000_0000 → both stale responses dropped (discard 2→0); first output pc 0x202, instr 0x0000_0513, compressed = 0.
- out_ready = 0 for 10 cycles → requests stop once occupied + outstanding = DEPTH; no data lost; release drains in order.
- rvalid with err = 1 on word 0x108 → out_err_o = 1 at pc 0x108, out_instr_o = 0, no further valid until redirect; redirect 0x300 resumes normally.
- Redirect in the same cycle as rvalid and out_valid & out_ready → FIFO empty next cycle, discard = outstanding − 1, out_pc = new target.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction prefetch unit
package fetch_pkg;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } fifo_entry_t;

    localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != OPC_UNCOMPRESSED;
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - combinational 16/32-bit realignment of the two oldest fetched words
module fetch_aligner
    import fetch_pkg::*;
(
    input  fifo_entry_t entry0_i,
    input  logic [15:0] entry1_lo_i,
    input  logic        entry1_err_i,
    input  logic [15:0] bypass_lo_i,
    input  logic        bypass_err_i,
    input  logic        bypass_valid_i,
    input  logic        occ0_i,
    input  logic        occ1_i,
    input  logic        pc_hi_i,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        compressed_o,
    output logic        err_o,
    output logic        pop_o
);

    logic [15:0] upper_lo;
    logic        upper_err;
    logic        upper_valid;

    always_comb begin
        upper_lo    = occ1_i ? entry1_lo_i  : bypass_lo_i;
        upper_err   = occ1_i ? entry1_err_i : bypass_err_i;
        upper_valid = occ1_i | bypass_valid_i;

        instr_o = '0;
        valid_o = 1'b0;
        err_o   = 1'b0;
        pop_o   = 1'b0;

        if (occ0_i) begin
            if (entry0_i.err) begin
                valid_o = 1'b1;
                err_o   = 1'b1;
            end else if (!pc_hi_i) begin
                valid_o = 1'b1;
                if (is_compressed(entry0_i.data[1:0])) begin
                    instr_o = {16'h0000, entry0_i.data[15:0]};
                end else begin
                    instr_o = entry0_i.data;
                    pop_o   = 1'b1;
                end
            end else if (is_compressed(entry0_i.data[17:16])) begin
                valid_o = 1'b1;
                instr_o = {16'h0000, entry0_i.data[31:16]};
                pop_o   = 1'b1;
            end else if (upper_valid) begin
                // straddling instruction: upper half comes from entry1 or the word arriving now
                valid_o = 1'b1;
                pop_o   = 1'b1;
                if (upper_err) begin
                    err_o = 1'b1;
                end else begin
                    instr_o = {upper_lo, entry0_i.data[31:16]};
                end
            end
        end

        compressed_o = is_compressed(instr_o[1:0]);
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - RV32IC prefetch unit: request window, shift FIFO, aligner, redirect discard
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          NUM_REQS = 2,
    parameter int          DEPTH    = NUM_REQS + 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_compressed_o,
    output logic        out_err_o,
    output logic        busy_o
);

    localparam int            CW         = $clog2(DEPTH + NUM_REQS + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] NUM_REQS_C = CW'(NUM_REQS);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    fifo_entry_t   fifo_q [DEPTH];
    fifo_entry_t   fifo_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic          halt_q, halt_d;
    logic          run_q, run_d;

    logic [31:0]   al_instr;
    logic          al_valid, al_compressed, al_err, al_pop;
    logic          occ0, occ1, accept_rsp, grant, consume, push, pop;
    logic [CW-1:0] wr_idx;
    fifo_entry_t   rsp;

    assign rsp        = {instr_rdata_i, instr_err_i};
    assign occ0       = count_q != '0;
    assign occ1       = count_q > ONE_C;
    assign accept_rsp = instr_rvalid_i & (discard_q == '0);

    // run_q keeps the request line low for the first cycle out of reset
    assign instr_req_o  = run_q & fetch_en_i & ~redirect_i
                        & ((outst_q + count_q) < DEPTH_C)
                        & (outst_q < NUM_REQS_C);
    assign instr_addr_o = fetch_addr_q;
    assign grant        = instr_req_o & instr_gnt_i;

    fetch_aligner u_aligner (
        .entry0_i       (fifo_q[0]),
        .entry1_lo_i    (fifo_q[1].data[15:0]),
        .entry1_err_i   (fifo_q[1].err),
        .bypass_lo_i    (instr_rdata_i[15:0]),
        .bypass_err_i   (instr_err_i),
        .bypass_valid_i (accept_rsp),
        .occ0_i         (occ0),
        .occ1_i         (occ1),
        .pc_hi_i        (out_pc_q[1]),
        .instr_o        (al_instr),
        .valid_o        (al_valid),
        .compressed_o   (al_compressed),
        .err_o          (al_err),
        .pop_o          (al_pop)
    );

    assign out_valid_o      = al_valid & ~halt_q;
    assign out_instr_o      = al_instr;
    assign out_pc_o         = out_pc_q;
    assign out_compressed_o = al_compressed;
    assign out_err_o        = out_valid_o & al_err;
    assign busy_o           = (outst_q != '0) | occ0;

    assign consume = out_valid_o & out_ready_i & ~redirect_i;
    assign pop     = consume & al_pop;
    assign push    = accept_rsp & ~redirect_i;

    always_comb begin
        fifo_d       = fifo_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        outst_d      = outst_q + CW'(grant) - CW'(instr_rvalid_i);
        discard_d    = discard_q;
        fetch_addr_d = fetch_addr_q;
        out_pc_d     = out_pc_q;
        halt_d       = halt_q | (consume & al_err);
        run_d        = 1'b1;
        wr_idx       = pop ? (count_q - ONE_C) : count_q;

        if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - ONE_C;
        end
        if (grant) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end
        if (consume) begin
            out_pc_d = out_pc_q + (al_compressed ? 32'd2 : 32'd4);
        end

        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i + 1];
            end
        end
        // a simultaneous pop shifts everything down, so the push lands one slot lower
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    fifo_d[i] = rsp;
                end
            end
        end

        if (redirect_i) begin
            count_d      = '0;
            outst_d      = outst_q - CW'(instr_rvalid_i);
            discard_d    = outst_q - CW'(instr_rvalid_i);
            fetch_addr_d = redirect_addr_i & 32'hFFFF_FFFC;
            out_pc_d     = redirect_addr_i & 32'hFFFF_FFFE;
            halt_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            count_q      <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            fetch_addr_q <= PC_RESET & 32'hFFFF_FFFC;
            out_pc_q     <= PC_RESET;
            halt_q       <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            fifo_q       <= fifo_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
            fetch_addr_q <= fetch_addr_d;
            out_pc_q     <= out_pc_d;
            halt_q       <= halt_d;
            run_q        <= run_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - scoreboard bench with random bus timing and an instruction-stream model
module tb_fetch_prefetch_buffer;

    localparam logic [31:0] PC_RST = 32'h100;
    localparam int          NR     = 2;
    localparam int          MEMW   = 1024;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_en_i, redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_req_o, instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_instr_o, out_pc_o;
    logic        out_compressed_o, out_err_o, busy_o;

    always #5 clk = ~clk;

    fetch_prefetch_buffer #(.PC_RESET(PC_RST), .NUM_REQS(NR), .DEPTH(NR + 1)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .fetch_en_i       (fetch_en_i),
        .redirect_i       (redirect_i),
        .redirect_addr_i  (redirect_addr_i),
        .instr_req_o      (instr_req_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_addr_o     (instr_addr_o),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .instr_err_i      (instr_err_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_instr_o      (out_instr_o),
        .out_pc_o         (out_pc_o),
        .out_compressed_o (out_compressed_o),
        .out_err_o        (out_err_o),
        .busy_o           (busy_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        compressed;
        logic        err;
    } exp_t;

    logic [31:0] mem [MEMW];
    logic        mem_err [MEMW];
    exp_t        exp_q [$];
    logic [31:0] pend_q [$];
    exp_t        mon_e;
    logic [31:0] bus_a, hold_addr, rnd_ra;
    logic        hold_pending, rnd_rd;
    int          checks = 0, failures = 0, consumed = 0;
    int          gnt_pct = 100, rv_pct = 100, since = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = mem[widx(a)];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Expected instruction stream from a target: walk halfwords, stop at the first faulting fetch
    task automatic build_expect(input logic [31:0] target);
        logic [31:0] pc;
        logic [15:0] lo;
        exp_t        e;
        exp_q.delete();
        pc = {target[31:1], 1'b0};
        for (int n = 0; n < 200; n++) begin
            e  = '0;
            e.pc = pc;
            lo = half(pc);
            if (mem_err[widx(pc)]) begin
                e.err = 1'b1;
            end else if (lo[1:0] != 2'b11) begin
                e.instr      = {16'h0000, lo};
                e.compressed = 1'b1;
            end else if (mem_err[widx(pc + 32'd2)]) begin
                e.err = 1'b1;
            end else begin
                e.instr = {half(pc + 32'd2), lo};
            end
            exp_q.push_back(e);
            if (e.err) break;
            pc = pc + (e.compressed ? 32'd2 : 32'd4);
        end
    endtask

    // Bus slave: random grant, in-order responses with random latency, junk on idle data lines
    initial begin
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        instr_err_i    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            instr_gnt_i = rstn && ($urandom_range(99) < gnt_pct);
            if (rstn && pend_q.size() != 0 && $urandom_range(99) < rv_pct) begin
                bus_a          = pend_q.pop_front();
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem[widx(bus_a)];
                instr_err_i    = mem_err[widx(bus_a)];
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = $urandom;
                instr_err_i    = 1'($urandom_range(1));
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (hold_pending && !redirect_i && fetch_en_i) begin
                chk("req_held", 32'(instr_req_o), 32'd1);
                chk("addr_held", instr_addr_o, hold_addr);
            end
            hold_pending = instr_req_o && !instr_gnt_i;
            hold_addr    = instr_addr_o;
            if (instr_req_o && instr_gnt_i) begin
                pend_q.push_back(instr_addr_o);
                chk("outstanding_le_max", 32'(pend_q.size() <= NR), 32'd1);
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rstn && out_valid_o && out_ready_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output pc=%08h instr=%08h err=%0d required=none", out_pc_o, out_instr_o, out_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", out_pc_o, mon_e.pc);
                chk("out_err", 32'(out_err_o), 32'(mon_e.err));
                chk("out_instr", out_instr_o, mon_e.instr);
                if (!mon_e.err) chk("out_compressed", 32'(out_compressed_o), 32'(mon_e.compressed));
                consumed++;
            end
        end
    end

    task automatic step(input logic rd, input logic [31:0] ra);
        @(posedge clk);
        #1;
        redirect_i      = rd;
        redirect_addr_i = ra;
        if (rd) build_expect(ra);
    endtask

    initial begin
        rstn            = 1'b0;
        fetch_en_i      = 1'b1;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        out_ready_i     = 1'b0;
        hold_pending    = 1'b0;
        hold_addr       = '0;

        for (int i = 0; i < MEMW; i++) begin
            mem[i]     = $urandom;
            mem_err[i] = (i >= 256) && ($urandom_range(63) == 0);
        end
        for (int i = 'h40; i < 'h100; i++) mem[i] = NOP;
        mem['h41] = 32'h0001_4501;
        mem_err['h44] = 1'b1;
        mem['h80] = 32'h0513_0001;
        mem['h81] = 32'h0000_0000;

        repeat (3) @(negedge clk);
        chk("reset_req", 32'(instr_req_o), 32'd0);
        chk("reset_valid", 32'(out_valid_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_err", 32'(out_err_o), 32'd0);
        chk("reset_pc", out_pc_o, PC_RST);
        chk("reset_fetch_addr", instr_addr_o, PC_RST);

        // From reset: NOP, two compressed, NOPs, then a faulting word at 0x110
        build_expect(PC_RST);
        @(posedge clk);
        #1;
        rstn        = 1'b1;
        out_ready_i = 1'b1;
        repeat (40) step(1'b0, 32'h0);
        chk("err_stream_done", 32'(exp_q.size()), 32'd0);
        chk("err_halt_valid_low", 32'(out_valid_o), 32'd0);

        // Two requests left hanging, then redirect to an unaligned target
        rv_pct = 0;
        step(1'b1, 32'h180);
        repeat (4) step(1'b0, 32'h0);
        chk("req_blocked_at_max", 32'(instr_req_o), 32'd0);
        chk("busy_outstanding", 32'(busy_o), 32'd1);
        rv_pct = 100;
        step(1'b1, 32'h203);
        repeat (20) step(1'b0, 32'h0);

        // Decode stall: window must close once FIFO plus in-flight reach DEPTH
        step(1'b1, 32'h300);
        out_ready_i = 1'b0;
        repeat (12) step(1'b0, 32'h0);
        chk("stall_req_low", 32'(instr_req_o), 32'd0);
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_pc", out_pc_o, 32'h300);
        out_ready_i = 1'b1;
        repeat (20) step(1'b0, 32'h0);

        gnt_pct = 70;
        rv_pct  = 60;
        since   = 0;
        for (int c = 0; c < 3000; c++) begin
            rnd_rd = (since >= 60) || ($urandom_range(29) == 0);
            rnd_ra = 32'h400 + 32'($urandom_range(2047));
            @(posedge clk);
            #1;
            out_ready_i     = ($urandom_range(3) != 0);
            fetch_en_i      = ($urandom_range(9) != 0);
            redirect_i      = rnd_rd;
            redirect_addr_i = rnd_ra;
            if (rnd_rd) begin
                build_expect(rnd_ra);
                since = 0;
            end else begin
                since++;
            end
        end
        out_ready_i = 1'b1;
        fetch_en_i  = 1'b1;
        repeat (40) step(1'b0, 32'h0);
        chk("traffic_volume", 32'(consumed > 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
